// File: rtl/key_expansion_iter_if.sv
// Request, status and round-key read bus of key_expansion_iter.
interface key_expansion_iter_if;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    modport master (output start, key_in, rd_round, input busy, done, rd_key);
    modport slave  (input start, key_in, rd_round, output busy, done, rd_key);
endinterface

// File: rtl/key_expansion_iter.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a round-key store.
// Define KEYEXP_ZEROIZE_EN to bulk-clear the store on start and blank reads while busy.
module key_expansion_iter #(
    parameter int KEY_WORDS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    key_expansion_iter_if.slave bus
);
    localparam int NR          = KEY_WORDS + 6;
    localparam int TOTAL_WORDS = 4 * (NR + 1);
    localparam int WIDX        = $clog2(TOTAL_WORDS);

    generate
        if (KEY_WORDS != 4 && KEY_WORDS != 6 && KEY_WORDS != 8) begin : g_bad_key_words
            $error("key_expansion_iter: KEY_WORDS must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic {IDLE, GEN} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t            state;
    state_t            state_next;
    logic              last_word;
    logic              done_q;
    logic [WIDX-1:0]   idx;
    logic [2:0]        phase;
    logic [7:0]        rcon;
    logic [31:0]       words [TOTAL_WORDS];
    logic [31:0]       window [KEY_WORDS];
    logic [31:0]       key_word [8];
    logic [31:0]       prev_word;
    logic [31:0]       sub_in;
    logic [31:0]       sub_out;
    logic [31:0]       temp;
    logic [31:0]       new_word;
    logic [WIDX-1:0]   rd_base;
    logic [127:0]      rd_key_q;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            key_word[k] = bus.key_in[255 - 32 * k -: 32];
        end
    end

    // A new start wins over everything, including a run already in progress.
    always_comb begin
        state_next = state;
        last_word  = 1'b0;
        if (bus.start) begin
            state_next = GEN;
        end else if (state == GEN && idx == WIDX'(TOTAL_WORDS - 1)) begin
            state_next = IDLE;
            last_word  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= last_word;
        end
    end

    // The single SubWord: RotWord is applied first only on i mod Nk == 0 words.
    always_comb begin
        prev_word = window[KEY_WORDS - 1];
        sub_in    = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
        temp      = prev_word;
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (KEY_WORDS == 8 && phase == 3'd4) begin
            temp = sub_out;
        end
        new_word = window[0] ^ temp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
            for (int k = 0; k < TOTAL_WORDS; k++) begin
                words[k] <= '0;
            end
            for (int k = 0; k < KEY_WORDS; k++) begin
                window[k] <= '0;
            end
        end else if (bus.start) begin
`ifdef KEYEXP_ZEROIZE_EN
            for (int k = 0; k < TOTAL_WORDS; k++) begin
                words[k] <= '0;
            end
`endif
            for (int k = 0; k < KEY_WORDS; k++) begin
                words[k]  <= key_word[k];
                window[k] <= key_word[k];
            end
            idx   <= WIDX'(KEY_WORDS);
            phase <= '0;
            rcon  <= 8'h01;
        end else if (state == GEN) begin
            words[idx] <= new_word;
            for (int k = 0; k < KEY_WORDS - 1; k++) begin
                window[k] <= window[k + 1];
            end
            window[KEY_WORDS - 1] <= new_word;
            idx   <= idx + WIDX'(1);
            phase <= (phase == 3'(KEY_WORDS - 1)) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) begin
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

    assign rd_base = WIDX'({bus.rd_round, 2'b00});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_key_q <= '0;
        end else if (bus.rd_round > 4'(NR)) begin
            rd_key_q <= '0;
`ifdef KEYEXP_ZEROIZE_EN
        end else if (state_next == GEN) begin
            rd_key_q <= '0;
`endif
        end else begin
            rd_key_q <= {words[rd_base], words[rd_base + WIDX'(1)],
                         words[rd_base + WIDX'(2)], words[rd_base + WIDX'(3)]};
        end
    end

    assign bus.busy   = (state == GEN);
    assign bus.done   = done_q;
    assign bus.rd_key = rd_key_q;
endmodule
